// File: rtl/fft_out_collector.sv
// Double-buffered collector that reorders FFT results (any bin order) into
// natural-order frames and streams them out with valid/ready handshaking.
module fft_out_collector #(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18
) (
  input  logic                     iclk,
  input  logic                     rst_n,
  input  logic [TOTAL_STAGE_P-1:0] iaddr,
  input  logic [MULT_WIDTH_P-1:0]  iReal,
  input  logic [MULT_WIDTH_P-1:0]  iImag,
  input  logic                     ien,
  output logic [MULT_WIDTH_P-1:0]  oReal,
  output logic [MULT_WIDTH_P-1:0]  oImag,
  output logic [TOTAL_STAGE_P-1:0] oaddr,
  output logic                     ovalid,
  input  logic                     iready,
  output logic                     olast,
  output logic                     oovf
);

  localparam int N  = 1 << TOTAL_STAGE_P;
  localparam int DW = 2 * MULT_WIDTH_P;
  localparam logic [TOTAL_STAGE_P-1:0] LAST_IDX = '1;

  typedef enum logic {IDLE, STREAM} state_t;

  // Bank select is the MSB of the RAM address: {bank, bin}.
  logic [DW-1:0] mem [2*N];

  logic [1:0]               full, full_set, full_clr;
  logic [1:0]               issued, issued_set;
  logic                     wr_bank;
  logic [TOTAL_STAGE_P-1:0] wr_cnt;
  logic                     wr_accept, wr_done, drop;

  logic                     iss_bank;
  logic [TOTAL_STAGE_P-1:0] iss_ptr;
  logic                     issue;

  logic                     s1_valid;
  logic [TOTAL_STAGE_P-1:0] s1_addr;
  logic [DW-1:0]            ram_q;
  logic                     out_adv, s1_adv, release_bank;

  state_t                   state, state_nxt;
  logic                     rd_bank;
  logic                     rd_active;

  // Write side: a full bank refuses samples until its frame has drained.
  assign wr_accept = ien && !full[wr_bank];
  assign wr_done   = wr_accept && (wr_cnt == LAST_IDX);
  assign drop      = ien && full[wr_bank];

  // Two-stage read pipe (RAM register, output register); stage 1 may fill
  // while the output stalls so a stalled last sample never leaves a bubble.
  assign out_adv      = !ovalid || iready;
  assign s1_adv       = !s1_valid || out_adv;
  assign issue        = s1_adv && rd_active && full[iss_bank] && !issued[iss_bank];
  assign release_bank = ovalid && iready && olast;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    full_set   = '0;
    full_clr   = '0;
    issued_set = '0;
    full_set[wr_bank]    = wr_done;
    full_clr[rd_bank]    = release_bank;
    issued_set[iss_bank] = issue && (iss_ptr == LAST_IDX);
  end

  // NOTE: the bank RAM has no reset; clearing it would prevent RAM inference and no logic depends on its contents.
  always_ff @(posedge iclk) begin
    if (wr_accept) mem[{wr_bank, iaddr}] <= {iReal, iImag};
    if (issue)     ram_q <= mem[{iss_bank, iss_ptr}];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      full    <= '0;
      issued  <= '0;
      oovf    <= 1'b0;
    end else begin
      if (wr_accept) wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
      if (wr_done)   wr_bank <= ~wr_bank;
      if (drop)      oovf <= 1'b1;
      // Set and clear never target the same bank in one cycle.
      full   <= (full | full_set) & ~full_clr;
      issued <= (issued | issued_set) & ~full_clr;
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      iss_bank <= 1'b0;
      iss_ptr  <= '0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      if (issue) begin
        iss_ptr <= iss_ptr + 1'b1;
        if (iss_ptr == LAST_IDX) iss_bank <= ~iss_bank;
      end
      if (s1_adv) begin
        s1_valid <= issue;
        s1_addr  <= iss_ptr;
      end
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
      oaddr  <= '0;
      oReal  <= '0;
      oImag  <= '0;
    end else if (out_adv) begin
      ovalid <= s1_valid;
      olast  <= s1_valid && (s1_addr == LAST_IDX);
      if (s1_valid) begin
        oaddr          <= s1_addr;
        {oReal, oImag} <= ram_q;
      end
    end
  end

  // Read FSM: state register, next-state logic, output decode.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (release_bank) rd_bank <= ~rd_bank;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rd_bank]) state_nxt = STREAM;
      STREAM:  if (release_bank)  state_nxt = full[~rd_bank] ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reads may start in the IDLE cycle that sees the bank full, giving the
  // two-cycle full-to-ovalid latency.
  always_comb begin
    rd_active = (state == STREAM) || full[rd_bank];
  end

endmodule

// File: tb/tb_fft_out_collector.sv
// Self-checking bench: frame-level reference model (bank snapshots and an
// expected-output queue) compared against the collector on every cycle.
module tb_fft_out_collector;

  localparam int TSP = 3;
  localparam int W   = 18;
  localparam int N   = 8;

  logic           iclk = 1'b0;
  logic           rst_n = 1'b0;
  logic [TSP-1:0] iaddr = '0;
  logic [W-1:0]   iReal = '0;
  logic [W-1:0]   iImag = '0;
  logic           ien = 1'b0;
  logic           iready = 1'b0;
  logic [W-1:0]   oReal, oImag;
  logic [TSP-1:0] oaddr;
  logic           ovalid, olast, oovf;

  fft_out_collector #(.TOTAL_STAGE_P(TSP), .MULT_WIDTH_P(W)) dut (
    .iclk(iclk), .rst_n(rst_n), .iaddr(iaddr), .iReal(iReal), .iImag(iImag),
    .ien(ien), .oReal(oReal), .oImag(oImag), .oaddr(oaddr), .ovalid(ovalid),
    .iready(iready), .olast(olast), .oovf(oovf)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int vectors = 0;
  int errors  = 0;
  int k = 0;

  typedef struct {
    logic [TSP-1:0] addr;
    logic [W-1:0]   re;
    logic [W-1:0]   im;
    logic           bank;
    int             rdy;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_re[2][N];
  logic [W-1:0] m_im[2][N];
  logic [1:0]   m_full = '0;
  logic         m_wb = 1'b0;
  int           m_cnt = 0;
  logic         m_ovf = 1'b0;

  int n_xfer, n_olast, cur_run, max_run, first_valid_k, last_wr_k, rcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic clear_stats();
    n_xfer = 0; n_olast = 0; cur_run = 0; max_run = 0; first_valid_k = -1;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic en, input logic [TSP-1:0] a,
                      input logic [W-1:0] re, input logic [W-1:0] im, input logic rdy);
    logic       exp_v;
    logic [1:0] saved;
    exp_t       h;
    @(negedge iclk);
    ien = en; iaddr = a; iReal = re; iImag = im; iready = rdy;
    #1;
    exp_v = (exp_q.size() > 0) && (exp_q[0].rdy < k);
    check("ovalid", ovalid, exp_v);
    check("oovf", oovf, m_ovf);
    if (exp_v && ovalid) begin
      check("oaddr", oaddr, exp_q[0].addr);
      check("oReal", oReal, exp_q[0].re);
      check("oImag", oImag, exp_q[0].im);
      check("olast", olast, exp_q[0].addr == TSP'(N-1));
    end
    if (ovalid === 1'b1) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (first_valid_k < 0) first_valid_k = k;
      if (rdy) begin
        n_xfer++;
        if (olast) n_olast++;
      end
    end else cur_run = 0;

    saved = m_full;
    if (exp_v && rdy) begin
      h = exp_q.pop_front();
      if (h.addr == TSP'(N-1)) m_full[h.bank] = 1'b0;
    end
    if (en) begin
      if (saved[m_wb]) m_ovf = 1'b1;
      else begin
        m_re[m_wb][a] = re;
        m_im[m_wb][a] = im;
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0;
          m_full[m_wb] = 1'b1;
          for (int i = 0; i < N; i++)
            exp_q.push_back('{addr: TSP'(i), re: m_re[m_wb][i], im: m_im[m_wb][i],
                              bank: m_wb, rdy: k + 2});
          m_wb = ~m_wb;
        end
      end
    end
    @(posedge iclk);
    k++;
  endtask

  function automatic logic rdy_of(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (rcnt % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, '0, '0, rdy_of(mode));
      rcnt++;
    end
  endtask

  // Bit-reversed frame: iReal = bin*10 + base*100, iImag = -bin.
  task automatic send_br_frame(input int gap, input int mode, input int base, input int count);
    logic [TSP-1:0] sv, a;
    for (int s = 0; s < count; s++) begin
      sv = TSP'(s);
      a  = {sv[0], sv[1], sv[2]};
      last_wr_k = k;
      step(1'b1, a, W'(int'(a) * 10 + base * 100), W'(-int'(a)), rdy_of(mode));
      rcnt++;
      for (int g = 0; g < gap; g++) begin
        step(1'b0, '0, '0, '0, rdy_of(mode));
        rcnt++;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge iclk);
    rst_n = 1'b0; ien = 1'b0; iready = 1'b0;
    #1;
    check("rst_ovalid", ovalid, 0);
    check("rst_olast", olast, 0);
    check("rst_oovf", oovf, 0);
    check("rst_oaddr", oaddr, 0);
    check("rst_oReal", oReal, 0);
    check("rst_oImag", oImag, 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge iclk);
      k++;
    end
    #1;
    check("rst_hold_ovalid", ovalid, 0);
    exp_q.delete();
    m_full = '0; m_wb = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic en, rdy;
    int   pct;
    rcnt = 0;
    clear_stats();
    do_reset(3);

    // Single bit-reversed frame, iready held high.
    clear_stats();
    send_br_frame(0, 0, 0, N);
    check("pin_qsize", exp_q.size(), 8);
    check("pin_re3", exp_q[3].re, 30);
    check("pin_im7", exp_q[7].im, 18'h3FFF9);
    idle(12, 0);
    check("latency", first_valid_k - last_wr_k, 3);
    check("xfer_single", n_xfer, 8);
    check("olast_single", n_olast, 1);

    // Same frame with iready stalls.
    clear_stats();
    rcnt = 0;
    send_br_frame(0, 1, 0, N);
    idle(40, 1);
    check("xfer_stall", n_xfer, 8);
    check("olast_stall", n_olast, 1);

    // Two frames back to back, continuous drain.
    clear_stats();
    send_br_frame(0, 0, 1, N);
    send_br_frame(0, 0, 2, N);
    idle(12, 0);
    check("run_b2b", max_run, 16);
    check("olast_b2b", n_olast, 2);

    // Three frames with the sink stalled: third frame overflows.
    clear_stats();
    send_br_frame(0, 2, 3, N);
    send_br_frame(0, 2, 4, N);
    send_br_frame(0, 2, 5, N);
    idle(20, 0);
    check("oovf_after_ovf", oovf, 1);
    check("xfer_ovf", n_xfer, 16);

    // Frame with three idle cycles between samples.
    clear_stats();
    send_br_frame(3, 0, 0, N);
    idle(12, 0);
    check("latency_gap", first_valid_k - last_wr_k, 3);
    check("xfer_gap", n_xfer, 8);

    // Reset mid-frame, then a fresh frame.
    send_br_frame(0, 0, 6, 4);
    do_reset(2);
    clear_stats();
    send_br_frame(0, 0, 7, N);
    idle(12, 0);
    check("xfer_after_rst", n_xfer, 8);
    check("oovf_after_rst", oovf, 0);

    // Randomized traffic: repeated bins, gaps, and three sink-readiness phases.
    for (int i = 0; i < 1500; i++) begin
      pct = ((i / 300) % 3 == 0) ? 90 : ((i / 300) % 3 == 1) ? 50 : 10;
      en  = $urandom_range(0, 99) < 70;
      rdy = $urandom_range(0, 99) < pct;
      step(en, TSP'($urandom), W'($urandom), W'($urandom), rdy);
    end
    idle(30, 0);
    check("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
